// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and read-mode constants for the single-clock FIFO family
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_thr_if.sv
// sync_fifo_thr_if: producer/consumer bus of the threshold FIFO (controls, data and status)
interface sync_fifo_thr_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) ();

    localparam int CW = cnt_w(DEPTH);

    logic                  clr;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  wfull;
    logic                  rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, winc, wdata, rinc,
        input  rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, winc, wdata, rinc,
        output rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO storage array, synchronous write port and asynchronous read port
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PW         = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // storage is deliberately not reset; only accepted writes touch it
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: single-clock FIFO with thresholds, occupancy count, sticky errors and std/FWFT read
module sync_fifo_thr import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic            CLK,
    input  logic            RST,
    sync_fifo_thr_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]         waddr, raddr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem_rdata, rdata_q;
    logic                  rvalid_q, overflow, underflow;
    logic                  wfull, rempty, wa, ra;

    // pointers wrap by explicit compare so any DEPTH works, not only powers of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wfull  = count == CW'(DEPTH);
    assign rempty = count == '0;
    assign wa     = bus.winc & ~wfull;
    assign ra     = bus.rinc & ~rempty;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PW         (PW)
    ) u_mem (
        .clk   (CLK),
        .we    (wa & ~bus.clr),
        .waddr (waddr),
        .wdata (bus.wdata),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

    // pointer, occupancy, sticky error and standard-mode output register; clr wins over traffic
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (bus.clr) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            if (wa) waddr <= ptr_inc(waddr);
            if (ra) raddr <= ptr_inc(raddr);
            if (wa & ~ra) count <= count + 1'b1;
            else if (ra & ~wa) count <= count - 1'b1;
            if (bus.winc & wfull) overflow <= 1'b1;
            if (bus.rinc & rempty) underflow <= 1'b1;
            rvalid_q <= ra;
            if (ra) rdata_q <= mem_rdata;
        end
    end

    // in FWFT mode the head is shown directly, forced to zero while nothing is stored
    assign bus.rdata        = (FWFT == FIFO_MODE_FWFT) ? (rempty ? '0 : mem_rdata) : rdata_q;
    assign bus.rvalid       = (FWFT == FIFO_MODE_FWFT) ? ~rempty : rvalid_q;
    assign bus.wfull        = wfull;
    assign bus.rempty       = rempty;
    assign bus.almost_full  = count >= CW'(AF_LEVEL);
    assign bus.almost_empty = count <= CW'(AE_LEVEL);
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: doc/sync_fifo_thr.md
Name: sync_fifo_thr

Overview:
- Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
- Selectable read mode: standard (registered read) or first-word-fall-through (FWFT).
- Used inside single-domain blocks (ALU/register-file command and result buffering) where the dual-clock FIFO is unnecessary.
- Generalises the existing FIFO:
  - arbitrary DEPTH (not only powers of two)
  - threshold flags
  - flush
  - error reporting

Parameters:
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 8, number of entries; any integer >= 2.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.

Ports:
- CLK, input, 1, single clock; all state changes on the rising edge.
- RST, input, 1, reset; asynchronous assert, active-high.
- clr, input, 1, synchronous flush: empties the FIFO and clears the sticky flags.
- winc, input, 1, write request.
- wdata, input, DATA_WIDTH, write data.
- rinc, input, 1, read request (pop).
- rdata, output, DATA_WIDTH, read data.
- rvalid, output, 1, standard mode: rdata is updated this cycle. FWFT mode: equals !rempty.
- wfull, output, 1, count == DEPTH.
- rempty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_LEVEL.
- almost_empty, output, 1, count <= AE_LEVEL.
- count, output, $clog2(DEPTH+1), current occupancy.
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset (RST=1, asynchronous): all outputs return to the reset value below; memory contents are not reset.
  - count=0, rempty=1, wfull=0, almost_empty=1
  - almost_full=0 (all legal AF_LEVEL >= 1)
  - rvalid=0, rdata=0, overflow=0, underflow=0
  - waddr=0, raddr=0
- Write accepted (wa) = winc & !wfull. Read accepted (ra) = rinc & !rempty. Both are evaluated on the registered flags of the current cycle.
- Address pointers:
  - waddr and raddr are in range 0..DEPTH-1.
  - Increment on accept; wrap from DEPTH-1 to 0 by explicit compare, not binary overflow.
- count next-state:
  - +1 if wa & !ra
  - -1 if ra & !wa
  - unchanged if both or neither
- All flags are decoded from the registered count and update in the same cycle as count.
- Write latency: data written at edge N raises count at edge N; rempty deasserts after edge N.
- Standard mode (FWFT=0):
  - On ra at edge N, rdata <= mem[raddr] and rvalid=1 for the following cycle.
  - Without ra, rvalid=0 and rdata holds its last value.
- FWFT mode (FWFT=1):
  - rdata = mem[raddr] combinationally; valid whenever rempty=0.
  - ra pops the head; the next word appears after the edge.
  - rvalid = !rempty.
- Simultaneous winc & rinc:
  - Full: read accepted, write rejected (wfull registered), overflow set; count becomes DEPTH-1.
  - Empty: write accepted, read rejected, underflow set; count becomes 1.
  - Otherwise: both accepted, count unchanged.
  - FWFT, count==1: pop the old head; the new word becomes the head after the edge.
- Sticky flags:
  - winc & wfull sets overflow; rinc & rempty sets underflow.
  - Cleared only by clr or RST.
- clr (synchronous), priority over winc/rinc in the same cycle:
  - Sets pointers and count to 0; clears overflow, underflow and rvalid; rdata holds.
  - A same-cycle write is dropped without setting overflow.
- RST asserted mid-operation: immediate return to the reset state; in-flight data is lost.
- Memory: write-only port driven by wa; no read-before-write hazard, because a location is never read and written in the same cycle unless count==0 (read rejected) or count==DEPTH (write rejected).

Decomposition:
- Shared package fifo_pkg:
  - ptr_w(depth) = $clog2(depth) (min 1) and cnt_w(depth) = $clog2(depth+1) width functions
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1 constants
- One sub-module: sync_fifo_mem
  - DATA_WIDTH x DEPTH register array
  - synchronous write port (we, waddr, wdata)
  - asynchronous read port (raddr, rdata)
  - the std/FWFT output register lives in the top.
- Top holds pointer, count, flag and sticky logic.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2 unless stated):
- Reset then idle 3 cycles -> count=0, rempty=1, almost_empty=1, wfull=0, almost_full=0, rvalid=0, rdata=0x00.
- Write 0x10..0x17 back-to-back, then read all, FWFT=0 -> outputs track fill then drain:
  - almost_empty drops after the 3rd write (count=3); almost_full rises after the 6th (count=6); wfull after the 8th.
  - Reads return 0x10..0x17 in order, each with rvalid one cycle after its rinc; rempty after the 8th read.
- Full FIFO, winc=1 with wdata=0xAA for 2 cycles -> count stays 8, overflow=1 and stays set; then clr -> count=0, overflow=0, rempty=1.
- Empty FIFO, winc=rinc=1 with wdata=0x55 -> count=1, underflow=1, rvalid=0 (FWFT=0); next cycle read -> rdata=0x55.
- DEPTH=5, FWFT=1: 12 writes interleaved with 12 reads, keeping count between 1 and 5 -> pointers wrap 4->0; rdata shows each head while rempty=0; the sequence is read back in order; wfull is reached at count=5.
- Write 3 words, assert RST for 1 cycle mid-burst (async, off clock edge) -> outputs return to reset values immediately; a subsequent write of 0x77 is read back as the first word.
